// File: rtl/seq_shift_reg.sv
// WIDTH-bit register with parallel load and a multi-cycle serial shifter (start/busy/done).
// Define SEQ_SHIFT_ROTATE_EN to make mode 11 rotate right; otherwise mode 11 acts as SRL.
module seq_shift_reg #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               En,
  input  logic               ld,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state, nxt_state;
  logic [SHAMT_W-1:0] cnt, nxt_cnt;
  logic [1:0]         mode_q, nxt_mode;
  logic [WIDTH-1:0]   nxt_out, shifted;

  // One-bit step of the current value according to the mode latched at start.
  always_comb begin
    shifted = {1'b0, out[WIDTH-1:1]};
    case (mode_q)
      2'b00:   shifted = {out[WIDTH-2:0], 1'b0};
      2'b01:   shifted = {1'b0, out[WIDTH-1:1]};
      2'b10:   shifted = {out[WIDTH-1], out[WIDTH-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
      2'b11:   shifted = {out[0], out[WIDTH-1:1]};
`else
      2'b11:   shifted = {1'b0, out[WIDTH-1:1]};
`endif
      default: shifted = {1'b0, out[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_out   = out;
    nxt_cnt   = cnt;
    nxt_mode  = mode_q;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_out   = in;
          nxt_cnt   = shamt;
          nxt_mode  = mode;
          nxt_state = (shamt != '0) ? SHIFT : DONE;
        end else if (ld) begin
          nxt_out = in;
        end
      end
      SHIFT: begin
        nxt_out = shifted;
        nxt_cnt = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) nxt_state = DONE;
      end
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // En gates every state element, so a pending done pulse survives a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      cnt    <= '0;
      mode_q <= 2'b00;
    end else if (En) begin
      state  <= nxt_state;
      out    <= nxt_out;
      cnt    <= nxt_cnt;
      mode_q <= nxt_mode;
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_reg.sv
// Scoreboard bench for seq_shift_reg: stimulus queues expected results, a monitor checks them on done.
module tb_seq_shift_reg;

  logic        clk, rst, En, ld, start;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [15:0] in, out;
  logic        busy, done;

  typedef struct {
    logic [15:0] res;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  seq_shift_reg #(.WIDTH(16), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .En(En), .ld(ld), .start(start), .mode(mode),
    .shamt(shamt), .in(in), .out(out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every rising done pops one expected result.
  initial begin
    logic doneprev;
    exp_t e;
    doneprev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !doneprev) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          checkOutput(e.name, {16'h0, out}, {16'h0, e.res});
        end
      end
      doneprev = done;
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [4:0] sa, input logic [15:0] d,
                               input logic [15:0] exp, input int explat, input int stallat,
                               input bit ldbusy, input bit withld, input bit holddone,
                               input string name);
    exp_t e;
    int   lat;
    @(negedge clk);
    start = 1'b1; ld = withld; mode = m; shamt = sa; in = d;
    e.res = exp; e.name = name;
    q.push_back(e);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0; ld = 1'b0;
      if (c == 1) checkOutput({name, "_busy"}, {31'h0, busy}, {31'h0, (sa != 5'd0)});
      if (done) begin
        lat = c;
        break;
      end
      if (ldbusy && c == 1) begin ld = 1'b1; in = 16'hFFFF; end
      if (c == stallat) En = 1'b0;
      if (c == stallat + 2) En = 1'b1;
    end
    if (lat == 0) $display("[TB] FAIL %s_timeout: got no done, expected done within 100 cycles", name);
    checkOutput({name, "_lat"}, lat, explat);
    if (holddone && lat != 0) begin
      En = 1'b0;
      @(negedge clk);
      checkOutput({name, "_donehold"}, {31'h0, done}, 32'd1);
      En = 1'b1;
      @(negedge clk);
      checkOutput({name, "_doneclr"}, {31'h0, done}, 32'd0);
    end
    En = 1'b1;
  endtask

  initial begin
    logic [15:0] rorone, ror16;
    bit          sawact;
`ifdef SEQ_SHIFT_ROTATE_EN
    rorone = 16'h8000;
    ror16  = 16'h1234;
`else
    rorone = 16'h0000;
    ror16  = 16'h0000;
`endif
    rst = 1'b1; En = 1'b1; ld = 1'b0; start = 1'b0; mode = 2'b00; shamt = '0; in = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_out", {16'h0, out}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;

    ld = 1'b1; in = 16'hA5A5;
    @(negedge clk);
    ld = 1'b0;
    checkOutput("ld_out", {16'h0, out}, 32'hA5A5);
    checkOutput("ld_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    checkOutput("ld_done", {31'h0, done}, 32'h0);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1 checkOutput("async_rst_out", {16'h0, out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //           mode   shamt  in        expected lat stall ldb  ld   hold
    applyStimulus(2'b00, 5'd4,  16'h0001, 16'h0010, 5,  -10, 1'b0, 1'b0, 1'b0, "sll4");
    applyStimulus(2'b00, 5'd0,  16'h0001, 16'h0001, 1,  -10, 1'b0, 1'b0, 1'b1, "sll0");
    applyStimulus(2'b01, 5'd3,  16'h8000, 16'h1000, 4,  -10, 1'b0, 1'b0, 1'b0, "srl3");
    applyStimulus(2'b10, 5'd3,  16'h8000, 16'hF000, 4,  -10, 1'b0, 1'b0, 1'b0, "sra3");
    applyStimulus(2'b10, 5'd15, 16'h8000, 16'hFFFF, 16, -10, 1'b0, 1'b0, 1'b0, "sra15");
    applyStimulus(2'b00, 5'd5,  16'h0003, 16'h0060, 8,  2,   1'b1, 1'b0, 1'b0, "sll_stall");
    applyStimulus(2'b01, 5'd4,  16'h00F0, 16'h000F, 5,  -10, 1'b0, 1'b1, 1'b0, "start_ld");
    applyStimulus(2'b11, 5'd1,  16'h0001, rorone,   2,  -10, 1'b0, 1'b0, 1'b0, "ror1");
    applyStimulus(2'b11, 5'd16, 16'h1234, ror16,    17, -10, 1'b0, 1'b0, 1'b0, "ror16");
    applyStimulus(2'b00, 5'd20, 16'h1234, 16'h0000, 21, -10, 1'b0, 1'b0, 1'b0, "sll20");

    // Reset in the middle of a shift aborts with no later done.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; shamt = 5'd8; in = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midshift_out", {16'h0, out}, 32'h0008);
    #2 rst = 1'b1;
    #1 checkOutput("midrst_out", {16'h0, out}, 32'h0);
    checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sawact = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) sawact = 1'b1;
    end
    checkOutput("midrst_quiet", {31'h0, sawact}, 32'h0);
    checkOutput("queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
